adxl357_i2c_sequencer: RTL and testbench

Sequencer that owns the control/address/data inputs of the ADXL357 I2C controller.
- After i_start, checks the device ID, then runs a fixed configuration table (soft reset, range, filter, measurement mode).
- Then switches the controller to hardware 11-byte streaming, driven by the sensor DRDY pin.
- Arbitrates occasional CPU single-register accesses against streaming: the CPU wins only at a sample boundary.

---
 rtl/adxl357_pkg.sv | 49 ++++
 rtl/i2c_txn_issuer.sv | 116 +++++++++++
 rtl/adxl357_i2c_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_adxl357_i2c_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl357_pkg.sv
// Shared constants and types for the ADXL357 I2C sequencer: register map,
// controller op modes, error codes and state encodings.
package adxl357_pkg;

    localparam logic [7:0] REG_DEVID_AD  = 8'h00;
    localparam logic [7:0] REG_FILTER    = 8'h28;
    localparam logic [7:0] REG_RANGE     = 8'h2C;
    localparam logic [7:0] REG_POWER_CTL = 8'h2D;
    localparam logic [7:0] REG_RESET     = 8'h2F;
    localparam logic [7:0] RESET_CODE    = 8'h52;

    // Cycles the controller must look idle in S_DRAIN before the bus is
    // handed to the CPU; covers the status synchroniser lag after a DRDY.
    localparam int DRAIN_GUARD = 4;

    typedef enum logic [1:0] {
        CPU_1  = 2'b00,
        CPU_11 = 2'b01,
        HW_11  = 2'b10
    } op_mode_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_DEVID   = 2'd2
    } err_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RST_WAIT,
        S_STREAM,
        S_DRAIN,
        S_CPU_ISSUE,
        S_CPU_WAIT_ACK,
        S_CPU_WAIT_DONE,
        S_ERR
    } seq_state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_ISSUE,
        T_WAIT_ACK,
        T_WAIT_DONE
    } txn_state_e;

endpackage

// File: rtl/i2c_txn_issuer.sv
// One CPU_1 controller transaction: wait ready, raise enable until sm_enable,
// then wait for completion; a per-transaction timeout aborts the handshake.
module i2c_txn_issuer
    import adxl357_pkg::*;
#(
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_go,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_w_data,
    input  logic       i_rw,
    input  logic       i_rdy_s,
    input  logic       i_sme_s,
    input  logic [7:0] i_rd_byte,
    output logic       o_enable,
    output logic       o_rw,
    output logic [7:0] o_addr,
    output logic [7:0] o_w_data,
    output logic [7:0] o_rd_data,
    output logic       o_acked,
    output logic       o_done,
    output logic       o_timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    txn_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       enable_q, enable_d;
    logic       rw_q, rw_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] w_data_q, w_data_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       done_q, done_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enable_d  = enable_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        w_data_d  = w_data_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        if (state_q == T_IDLE) begin
            if (i_go) begin
                addr_d   = i_addr;
                w_data_d = i_w_data;
                rw_d     = i_rw;
                cnt_d    = '0;
                state_d  = T_ISSUE;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                T_ISSUE: if (i_rdy_s) begin
                    enable_d = 1'b1;
                    state_d  = T_WAIT_ACK;
                end
                T_WAIT_ACK: if (i_sme_s) begin
                    enable_d = 1'b0;
                    state_d  = T_WAIT_DONE;
                end
                T_WAIT_DONE: if (!i_sme_s && i_rdy_s) begin
                    done_d    = 1'b1;
                    rd_data_d = i_rd_byte;
                    state_d   = T_IDLE;
                end
                default: state_d = T_IDLE;
            endcase
            if (cnt_q == CW'(TIMEOUT_CYC - 1) && state_d != T_IDLE) begin
                timeout_d = 1'b1;
                enable_d  = 1'b0;
                state_d   = T_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= T_IDLE;
            cnt_q     <= '0;
            enable_q  <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            w_data_q  <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            enable_q  <= enable_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            w_data_q  <= w_data_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_enable  = enable_q;
    assign o_rw      = rw_q;
    assign o_addr    = addr_q;
    assign o_w_data  = w_data_q;
    assign o_rd_data = rd_data_q;
    assign o_acked   = (state_q == T_WAIT_DONE);
    assign o_done    = done_q;
    assign o_timeout = timeout_q;

endmodule

// File: rtl/adxl357_i2c_sequencer.sv
// Drives the ADXL357 I2C controller: DEVID check, configuration table, then
// DRDY-driven hardware streaming with CPU single-register accesses between samples.
module adxl357_i2c_sequencer
    import adxl357_pkg::*;
#(
    parameter int         TIMEOUT_CYC  = 2_000_000,
    parameter int         RST_WAIT_CYC = 500_000,
    parameter logic [7:0] DEVID_EXP    = 8'hAD
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_range,
    input  logic [3:0]  i_odr_lpf,
    input  logic [2:0]  i_clk_rate,
    input  logic        i_drdy_sensor,
    input  logic        i_cpu_req,
    input  logic        i_cpu_rw,
    input  logic [7:0]  i_cpu_reg_addr,
    input  logic [7:0]  i_cpu_w_data,
    input  logic [31:0] i_ctl_status,
    input  logic [31:0] i_ctl_accx,
    output logic [31:0] o_ctrl,
    output logic [7:0]  o_reg_addr,
    output logic [7:0]  o_w_data,
    output logic        o_drdy,
    output logic        o_cpu_done,
    output logic [7:0]  o_cpu_rd_data,
    output logic        o_streaming,
    output logic        o_sample_pulse,
    output logic [1:0]  o_err
);

    localparam int WCW = $clog2(RST_WAIT_CYC + DRAIN_GUARD + 1);

    seq_state_e     state_q, state_d;
    logic [2:0]     step_q, step_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    err_e           err_q, err_d;
    op_mode_e       op_mode_q, op_mode_d;
    logic [2:0]     clk_rate_q, clk_rate_d;
    logic           drdy_q, drdy_d;
    logic           cpu_done_q, cpu_done_d;
    logic [7:0]     cpu_rd_data_q, cpu_rd_data_d;
    logic           streaming_q, streaming_d;
    logic           sample_pulse_q, sample_pulse_d;
    logic           rdy_meta_q, rdy_meta_d, rdy_s_q, rdy_s_d;
    logic           sme_meta_q, sme_meta_d, sme_s_q, sme_s_d;
    logic           sme_prev_q, sme_prev_d;

    logic       txn_go, txn_rw;
    logic [7:0] txn_addr, txn_data;
    logic       txn_enable, txn_rw_q, txn_acked, txn_done, txn_timeout;
    logic [7:0] txn_addr_q, txn_data_q, txn_rd_data;
    logic       unused_bits;

    assign unused_bits = ^{i_ctl_status[31:11], i_ctl_status[9:1],
                           i_ctl_accx[31:20], i_ctl_accx[11:0]};

    i2c_txn_issuer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_issuer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_go      (txn_go),
        .i_addr    (txn_addr),
        .i_w_data  (txn_data),
        .i_rw      (txn_rw),
        .i_rdy_s   (rdy_s_q),
        .i_sme_s   (sme_s_q),
        .i_rd_byte (i_ctl_accx[19:12]),
        .o_enable  (txn_enable),
        .o_rw      (txn_rw_q),
        .o_addr    (txn_addr_q),
        .o_w_data  (txn_data_q),
        .o_rd_data (txn_rd_data),
        .o_acked   (txn_acked),
        .o_done    (txn_done),
        .o_timeout (txn_timeout)
    );

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q;
        op_mode_d     = op_mode_q;
        clk_rate_d    = i_clk_rate;
        drdy_d        = 1'b0;
        cpu_done_d    = 1'b0;
        cpu_rd_data_d = cpu_rd_data_q;
        rdy_meta_d    = i_ctl_status[0];
        rdy_s_d       = rdy_meta_q;
        sme_meta_d    = i_ctl_status[10];
        sme_s_d       = sme_meta_q;
        sme_prev_d    = sme_s_q;
        sample_pulse_d = sme_prev_q && !sme_s_q &&
                         (state_q == S_STREAM || state_q == S_DRAIN);
        txn_go   = 1'b0;
        txn_addr = '0;
        txn_data = '0;
        txn_rw   = 1'b0;

        case (state_q)
            S_IDLE: if (i_start) begin
                step_d  = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                txn_go  = 1'b1;
                state_d = S_WAIT_ACK;
                case (step_q)
                    3'd0: begin txn_addr = REG_DEVID_AD; txn_rw = 1'b1; end
                    3'd1: begin txn_addr = REG_RESET;  txn_data = RESET_CODE; end
                    3'd2: begin txn_addr = REG_RANGE;  txn_data = {6'b0, i_range}; end
                    3'd3: begin txn_addr = REG_FILTER; txn_data = {4'b0, i_odr_lpf}; end
                    default: txn_addr = REG_POWER_CTL;
                endcase
            end
            S_WAIT_ACK, S_WAIT_DONE: begin
                if (txn_timeout) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else if (txn_done) begin
                    case (step_q)
                        3'd0: if (txn_rd_data != DEVID_EXP) begin
                            err_d   = ERR_DEVID;
                            state_d = S_ERR;
                        end else begin
                            step_d  = 3'd1;
                            state_d = S_ISSUE;
                        end
                        3'd1: begin
                            wait_cnt_d = '0;
                            state_d    = S_RST_WAIT;
                        end
                        3'd4: begin
                            op_mode_d = HW_11;
                            state_d   = S_STREAM;
                        end
                        default: begin
                            step_d  = step_q + 3'd1;
                            state_d = S_ISSUE;
                        end
                    endcase
                end else if (txn_acked) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_RST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (wait_cnt_q == WCW'(RST_WAIT_CYC - 1)) begin
                    step_d  = 3'd2;
                    state_d = S_ISSUE;
                end
            end
            S_STREAM: begin
                drdy_d = i_drdy_sensor;
                // cpu_done_q masks the request the CPU has not yet dropped.
                if (i_cpu_req && !cpu_done_q) begin
                    drdy_d     = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!sme_s_q && rdy_s_q) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WCW'(DRAIN_GUARD - 1)) begin
                        op_mode_d = CPU_1;
                        state_d   = S_CPU_ISSUE;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            S_CPU_ISSUE: begin
                txn_go   = 1'b1;
                txn_addr = i_cpu_reg_addr;
                txn_data = i_cpu_w_data;
                txn_rw   = i_cpu_rw;
                state_d  = S_CPU_WAIT_ACK;
            end
            S_CPU_WAIT_ACK, S_CPU_WAIT_DONE: begin
                if (txn_timeout) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_ERR;
                end else if (txn_done) begin
                    cpu_done_d    = 1'b1;
                    cpu_rd_data_d = txn_rw_q ? txn_rd_data : 8'h00;
                    op_mode_d     = HW_11;
                    state_d       = S_STREAM;
                end else if (txn_acked) begin
                    state_d = S_CPU_WAIT_DONE;
                end
            end
            S_ERR: begin
                if (i_start) begin
                    err_d     = ERR_NONE;
                    step_d    = '0;
                    op_mode_d = CPU_1;
                    state_d   = S_ISSUE;
                end else if (i_cpu_req && !cpu_done_q) begin
                    cpu_done_d    = 1'b1;
                    cpu_rd_data_d = 8'h00;
                end
            end
            default: state_d = S_IDLE;
        endcase

        streaming_d = (state_d == S_STREAM);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= S_IDLE;
            step_q         <= '0;
            wait_cnt_q     <= '0;
            err_q          <= ERR_NONE;
            op_mode_q      <= CPU_1;
            clk_rate_q     <= '0;
            drdy_q         <= 1'b0;
            cpu_done_q     <= 1'b0;
            cpu_rd_data_q  <= '0;
            streaming_q    <= 1'b0;
            sample_pulse_q <= 1'b0;
            rdy_meta_q     <= 1'b0;
            rdy_s_q        <= 1'b0;
            sme_meta_q     <= 1'b0;
            sme_s_q        <= 1'b0;
            sme_prev_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            wait_cnt_q     <= wait_cnt_d;
            err_q          <= err_d;
            op_mode_q      <= op_mode_d;
            clk_rate_q     <= clk_rate_d;
            drdy_q         <= drdy_d;
            cpu_done_q     <= cpu_done_d;
            cpu_rd_data_q  <= cpu_rd_data_d;
            streaming_q    <= streaming_d;
            sample_pulse_q <= sample_pulse_d;
            rdy_meta_q     <= rdy_meta_d;
            rdy_s_q        <= rdy_s_d;
            sme_meta_q     <= sme_meta_d;
            sme_s_q        <= sme_s_d;
            sme_prev_q     <= sme_prev_d;
        end
    end

    assign o_ctrl         = {25'b0, clk_rate_q, op_mode_q, txn_rw_q, txn_enable};
    assign o_reg_addr     = txn_addr_q;
    assign o_w_data       = txn_data_q;
    assign o_drdy         = drdy_q;
    assign o_cpu_done     = cpu_done_q;
    assign o_cpu_rd_data  = cpu_rd_data_q;
    assign o_streaming    = streaming_q;
    assign o_sample_pulse = sample_pulse_q;
    assign o_err          = err_q;

endmodule

// File: tb/tb_adxl357_i2c_sequencer.sv
// Directed bench: a behavioural I2C controller model answers the sequencer,
// and each task checks one feature against hand-computed values.
module tb_adxl357_i2c_sequencer;

    localparam int TIMEOUT_CYC  = 1000;
    localparam int RST_WAIT_CYC = 50;
    localparam int CPU_LEN      = 30;
    localparam int HW_LEN       = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  range = 2'b10;
    logic [3:0]  odr = 4'h5;
    logic [2:0]  clk_rate = 3'b101;
    logic        drdy_sensor = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_rw = 1'b0;
    logic [7:0]  cpu_addr = 8'h00;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [31:0] ctl_status = 32'h0000_0001;
    logic [31:0] ctl_accx = 32'hABC0_0123;
    logic [31:0] o_ctrl;
    logic [7:0]  o_reg_addr, o_w_data, o_cpu_rd_data;
    logic        o_drdy, o_cpu_done, o_streaming, o_sample_pulse;
    logic [1:0]  o_err;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int done_cnt = 0;

    // controller model state
    logic [7:0] m_regs [256];
    bit         never_ack = 1'b0;
    int         m_cnt = 0;
    bit         m_hw = 1'b0;
    int         m_samples = 0;
    int         m_last_sample_end = 0;
    logic [7:0] m_rd = 8'h00;
    logic [7:0] log_addr [$];
    logic [7:0] log_data [$];
    logic       log_rw [$];
    int         log_cyc [$];

    adxl357_i2c_sequencer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RST_WAIT_CYC(RST_WAIT_CYC),
        .DEVID_EXP   (8'hAD)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_range       (range),
        .i_odr_lpf     (odr),
        .i_clk_rate    (clk_rate),
        .i_drdy_sensor (drdy_sensor),
        .i_cpu_req     (cpu_req),
        .i_cpu_rw      (cpu_rw),
        .i_cpu_reg_addr(cpu_addr),
        .i_cpu_w_data  (cpu_wdata),
        .i_ctl_status  (ctl_status),
        .i_ctl_accx    (ctl_accx),
        .o_ctrl        (o_ctrl),
        .o_reg_addr    (o_reg_addr),
        .o_w_data      (o_w_data),
        .o_drdy        (o_drdy),
        .o_cpu_done    (o_cpu_done),
        .o_cpu_rd_data (o_cpu_rd_data),
        .o_streaming   (o_streaming),
        .o_sample_pulse(o_sample_pulse),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    // Controller model: CPU_1 transaction on enable, HW sample on gated DRDY.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_cnt == 0) begin
            if (o_ctrl[3:2] == 2'b00 && o_ctrl[0] && !never_ack) begin
                if (o_ctrl[1]) m_rd = m_regs[o_reg_addr];
                else m_regs[o_reg_addr] = o_w_data;
                log_addr.push_back(o_reg_addr);
                log_data.push_back(o_ctrl[1] ? m_rd : o_w_data);
                log_rw.push_back(o_ctrl[1]);
                log_cyc.push_back(cyc);
                $display("[%0d] txn %s addr=0x%02h data=0x%02h", cyc,
                         o_ctrl[1] ? "RD" : "WR", o_reg_addr, o_ctrl[1] ? m_rd : o_w_data);
                m_hw = 1'b0;
                m_cnt = CPU_LEN;
                ctl_status <= 32'h0000_0400;
            end else if (o_ctrl[3:2] == 2'b10 && o_drdy) begin
                m_hw = 1'b1;
                m_cnt = HW_LEN;
                ctl_status <= 32'h0000_0400;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                ctl_status <= 32'h0000_0001;
                if (m_hw) begin
                    m_samples = m_samples + 1;
                    m_last_sample_end = cyc;
                end else begin
                    ctl_accx <= {12'hABC, m_rd, 12'h123};
                end
            end
        end
    end

    always @(negedge clk) begin
        if (o_sample_pulse) pulse_cnt = pulse_cnt + 1;
        if (o_cpu_done) done_cnt = done_cnt + 1;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_rw.delete();
        log_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_ctrl !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", o_ctrl); end
        n_checks++;
        if ({o_reg_addr, o_w_data, o_cpu_rd_data} !== 24'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {o_reg_addr, o_w_data, o_cpu_rd_data});
        end
        n_checks++;
        if ({o_drdy, o_cpu_done, o_streaming, o_sample_pulse, o_err} !== 6'h0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0", {o_drdy, o_cpu_done, o_streaming, o_sample_pulse, o_err});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_devid_mismatch();
        m_regs[0] = 8'h00;
        clear_log();
        pulse_start();
        for (int i = 0; i < 500 && o_err == 2'd0; i++) @(negedge clk);
        n_checks++;
        if (o_err !== 2'd2) begin n_fail++; $display("FAIL devid_err: got %0d want 2", o_err); end
        n_checks++;
        if (log_addr.size() != 1 || log_rw[0] !== 1'b1 || log_addr[0] !== 8'h00) begin
            n_fail++; $display("FAIL devid_txns: got %0d txns want 1 read of 0x00", log_addr.size());
        end
        // CPU access in the error state completes at once with zero data
        cpu_rw = 1'b1; cpu_addr = 8'h2C; cpu_req = 1'b1;
        for (int i = 0; i < 10 && !o_cpu_done; i++) @(negedge clk);
        n_checks++;
        if (o_cpu_done !== 1'b1 || o_cpu_rd_data !== 8'h00) begin
            n_fail++; $display("FAIL err_cpu_done: got done=%b data=%h want 1/00", o_cpu_done, o_cpu_rd_data);
        end
        cpu_req = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (log_addr.size() != 1) begin n_fail++; $display("FAIL err_cpu_bus: got %0d txns want 1", log_addr.size()); end
    endtask

    task automatic test_init();
        logic [7:0] exp_addr [4];
        logic [7:0] exp_data [4];
        int gap;
        exp_addr = '{8'h2F, 8'h2C, 8'h28, 8'h2D};
        exp_data = '{8'h52, 8'h02, 8'h05, 8'h00};
        m_regs[0] = 8'hAD;
        clear_log();
        pulse_start();
        n_checks++;
        if (o_err !== 2'd0) begin n_fail++; $display("FAIL restart_err_clear: got %0d want 0", o_err); end
        for (int i = 0; i < 5000 && !o_streaming; i++) @(negedge clk);
        n_checks++;
        if (o_streaming !== 1'b1 || log_addr.size() != 5) begin
            n_fail++; $display("FAIL init_done: got streaming=%b txns=%0d want 1/5", o_streaming, log_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (log_rw[k+1] !== 1'b0 || log_addr[k+1] !== exp_addr[k] || log_data[k+1] !== exp_data[k]) begin
                    n_fail++; $display("FAIL init_write%0d: got %h=%h rw=%b want %h=%h", k,
                                       log_addr[k+1], log_data[k+1], log_rw[k+1], exp_addr[k], exp_data[k]);
                end
            end
            gap = log_cyc[2] - log_cyc[1];
            n_checks++;
            if (gap < RST_WAIT_CYC + CPU_LEN || gap > RST_WAIT_CYC + CPU_LEN + 20) begin
                n_fail++; $display("FAIL rst_wait_gap: got %0d want %0d..%0d", gap, RST_WAIT_CYC + CPU_LEN, RST_WAIT_CYC + CPU_LEN + 20);
            end
        end
        n_checks++;
        if (o_ctrl !== 32'h0000_0058) begin n_fail++; $display("FAIL stream_ctrl: got %h want 00000058", o_ctrl); end
    endtask

    task automatic test_start_busy();
        pulse_start();
        repeat (200) @(negedge clk);
        n_checks++;
        if (log_addr.size() != 5 || o_streaming !== 1'b1) begin
            n_fail++; $display("FAIL start_busy: got txns=%0d streaming=%b want 5/1", log_addr.size(), o_streaming);
        end
    endtask

    task automatic test_stream();
        int p0, s0;
        p0 = pulse_cnt;
        s0 = m_samples;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) drdy_sensor = 1'b1;
            @(negedge clk);
            if (k == 0) begin
                n_checks++;
                if (o_drdy !== 1'b1) begin n_fail++; $display("FAIL drdy_pass: got %b want 1", o_drdy); end
            end
            drdy_sensor = 1'b0;
            repeat (4000) @(negedge clk);
        end
        n_checks++;
        if (pulse_cnt - p0 != 3 || m_samples - s0 != 3) begin
            n_fail++; $display("FAIL stream_pulses: got pulses=%0d samples=%0d want 3/3", pulse_cnt - p0, m_samples - s0);
        end
    endtask

    task automatic test_cpu_read();
        int p0, s0, d0, n0;
        bit leak;
        p0 = pulse_cnt; s0 = m_samples; n0 = log_addr.size();
        leak = 1'b0;
        @(negedge clk) drdy_sensor = 1'b1;
        for (int i = 0; i < 20 && !(m_cnt != 0 && m_hw); i++) @(negedge clk);
        cpu_rw = 1'b1; cpu_addr = 8'h2C; cpu_req = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        for (int i = 0; i < 1000 && !o_cpu_done; i++) begin
            if (o_drdy) leak = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (o_cpu_done !== 1'b1 || o_cpu_rd_data !== 8'h02) begin
            n_fail++; $display("FAIL cpu_read: got done=%b data=%h want 1/02", o_cpu_done, o_cpu_rd_data);
        end
        cpu_req = 1'b0;
        drdy_sensor = 1'b0;
        n_checks++;
        if (leak) begin n_fail++; $display("FAIL drain_drdy: got o_drdy=1 want 0 while draining"); end
        n_checks++;
        if (m_samples - s0 != 1 || pulse_cnt - p0 != 1 || log_addr.size() != n0 + 1 || log_cyc[n0] <= m_last_sample_end) begin
            n_fail++; $display("FAIL sample_first: got samples=%0d pulses=%0d txns=%0d want 1/1/%0d with read after sample",
                               m_samples - s0, pulse_cnt - p0, log_addr.size(), n0 + 1);
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (o_streaming !== 1'b1 || o_ctrl[3:2] !== 2'b10 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL stream_resume: got streaming=%b mode=%b dones=%0d want 1/10/1",
                               o_streaming, o_ctrl[3:2], done_cnt - d0);
        end
    endtask

    task automatic test_cpu_write();
        int n0;
        n0 = log_addr.size();
        cpu_rw = 1'b0; cpu_addr = 8'h28; cpu_wdata = 8'h0C; cpu_req = 1'b1;
        for (int i = 0; i < 500 && !o_cpu_done; i++) @(negedge clk);
        cpu_req = 1'b0;
        n_checks++;
        if (log_addr.size() != n0 + 1 || log_rw[n0] !== 1'b0 || log_addr[n0] !== 8'h28 || log_data[n0] !== 8'h0C) begin
            n_fail++; $display("FAIL cpu_write: got txns=%0d want write 28=0C", log_addr.size() - n0);
        end
        repeat (3) @(negedge clk);
        cpu_rw = 1'b1; cpu_req = 1'b1;
        for (int i = 0; i < 500 && !o_cpu_done; i++) @(negedge clk);
        cpu_req = 1'b0;
        n_checks++;
        if (o_cpu_done !== 1'b1 || o_cpu_rd_data !== 8'h0C) begin
            n_fail++; $display("FAIL cpu_readback: got done=%b data=%h want 1/0C", o_cpu_done, o_cpu_rd_data);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
        pulse_start();
        for (int i = 0; i < 3000 && !(log_addr.size() == 4); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_ctrl !== 32'h0 || o_reg_addr !== 8'h00 || o_w_data !== 8'h00 || o_err !== 2'd0 || o_streaming !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got ctrl=%h addr=%h data=%h want all 0", o_ctrl, o_reg_addr, o_w_data);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
        pulse_start();
        for (int i = 0; i < 5000 && !o_streaming; i++) @(negedge clk);
        n_checks++;
        if (o_streaming !== 1'b1 || log_addr.size() != 5 || log_addr[0] !== 8'h00 || log_rw[0] !== 1'b1) begin
            n_fail++; $display("FAIL reset_restart: got streaming=%b txns=%0d want 1/5 from DEVID read",
                               o_streaming, log_addr.size());
        end
    endtask

    task automatic test_timeout();
        int en_cyc, err_cyc;
        en_cyc = -1; err_cyc = -1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        never_ack = 1'b1;
        pulse_start();
        for (int i = 0; i < 3000 && err_cyc < 0; i++) begin
            if (en_cyc < 0 && o_ctrl[0]) en_cyc = cyc;
            if (o_err != 2'd0) err_cyc = cyc;
            else @(negedge clk);
        end
        n_checks++;
        if (o_err !== 2'd1 || o_ctrl[0] !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err: got err=%0d enable=%b want 1/0", o_err, o_ctrl[0]);
        end
        n_checks++;
        if (en_cyc < 0 || err_cyc - en_cyc < TIMEOUT_CYC - 2 || err_cyc - en_cyc > TIMEOUT_CYC + 2) begin
            n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", err_cyc - en_cyc, TIMEOUT_CYC);
        end
        never_ack = 1'b0;
        pulse_start();
        n_checks++;
        if (o_err !== 2'd0) begin n_fail++; $display("FAIL timeout_restart: got %0d want 0", o_err); end
        repeat (100) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
        test_reset();
        test_devid_mismatch();
        test_init();
        test_start_busy();
        test_stream();
        test_cpu_read();
        test_cpu_write();
        test_reset_mid();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
